// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS main control: Moore FSM sequencing fetch/decode/execute/mem/write-back.
// Optional j support is enabled by defining MC_CONTROL_JUMP_EN.
module mc_control_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegDst,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic        ZeroExt,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUOp,
  output logic [5:0]  alu_funct,
  output logic        illegal_op,
  output logic [3:0]  state,
  output logic [31:0] instr_retired
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 32;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_REX    = 4'd7;
  localparam logic [3:0] S_RWB    = 4'd8;
  localparam logic [3:0] S_BEQ    = 4'd9;
  localparam logic [3:0] S_IEX    = 4'd10;
  localparam logic [3:0] S_IWB    = 4'd11;
`ifdef MC_CONTROL_JUMP_EN
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;

  logic [STATE_W-1:0] next_state;
  logic               retire;

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Retired-instruction counter, bumped on every completing return to FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instr_retired <= '0;
    else if (retire) instr_retired <= instr_retired + CNT_W'(1);
  end

  // Next-state and Moore output decode
  always_comb begin
    next_state  = S_IDLE;
    retire      = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ZeroExt     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    alu_funct   = 6'b000000;
    illegal_op  = 1'b0;

    case (state)
      S_IDLE: next_state = S_FETCH;

      S_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        PCWrite    = mem_ready;
        IRWrite    = mem_ready;
        next_state = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opcode)
          OP_LW, OP_SW:              next_state = S_MEMADR;
          OP_RTYPE:                  next_state = S_REX;
          OP_BEQ:                    next_state = S_BEQ;
          OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_IEX;
`ifdef MC_CONTROL_JUMP_EN
          OP_J:                      next_state = S_JUMP;
`endif
          default: begin
            illegal_op = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        next_state = mem_ready ? S_MEMWB : S_MEMRD;
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        retire     = mem_ready;
        next_state = mem_ready ? S_FETCH : S_MEMWR;
      end

      S_REX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 2'b10;
        alu_funct  = funct;
        next_state = S_RWB;
      end

      S_RWB: begin
        RegDst     = 1'b1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        retire      = 1'b1;
        next_state  = S_FETCH;
      end

      // Immediate ops reuse the R-type ALU path with a synthesized funct
      S_IEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b10;
        case (opcode)
          OP_ANDI: begin
            alu_funct = FN_AND;
            ZeroExt   = 1'b1;
          end
          OP_ORI: begin
            alu_funct = FN_OR;
            ZeroExt   = 1'b1;
          end
          default: alu_funct = FN_ADD;
        endcase
        next_state = S_IWB;
      end

      S_IWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end

`ifdef MC_CONTROL_JUMP_EN
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = 2'b10;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
`endif

      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed self-checking bench for mc_control_fsm; honours MC_CONTROL_JUMP_EN for the j scenario.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt;
  logic [1:0]  ALUSrcB, PCSource, ALUOp;
  logic [5:0]  alu_funct;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ZeroExt(ZeroExt), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .alu_funct(alu_funct), .illegal_op(illegal_op),
    .state(state), .instr_retired(instr_retired)
  );

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst RegWrite ALUSrcA ZeroExt | ALUSrcB | PCSource | ALUOp | alu_funct | illegal_op
  logic [23:0] ctrl;
  assign ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
                 RegWrite, ALUSrcA, ZeroExt, ALUSrcB, PCSource, ALUOp, alu_funct, illegal_op};

  localparam logic [23:0] C_IDLE   = 24'd0;
  localparam logic [23:0] C_FETCH  = {11'b1001_0100_000, 2'b01, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_FETCHW = {11'b0001_0000_000, 2'b01, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_DEC    = {11'b0000_0000_000, 2'b11, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_DECILL = {11'b0000_0000_000, 2'b11, 2'b00, 2'b00, 6'b000000, 1'b1};
  localparam logic [23:0] C_MEMADR = {11'b0000_0000_010, 2'b10, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_MEMRD  = {11'b0011_0000_000, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_MEMWB  = {11'b0000_0010_100, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_MEMWR  = {11'b0010_1000_000, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_REXADD = {11'b0000_0000_010, 2'b00, 2'b00, 2'b10, 6'b100000, 1'b0};
  localparam logic [23:0] C_RWB    = {11'b0000_0001_100, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0};
  localparam logic [23:0] C_BEQ    = {11'b0100_0000_010, 2'b00, 2'b01, 2'b01, 6'b000000, 1'b0};
  localparam logic [23:0] C_IEXORI = {11'b0000_0000_011, 2'b10, 2'b00, 2'b10, 6'b100101, 1'b0};
  localparam logic [23:0] C_IWB    = {11'b0000_0000_100, 2'b00, 2'b00, 2'b00, 6'b000000, 1'b0};
`ifdef MC_CONTROL_JUMP_EN
  localparam logic [23:0] C_JUMP   = {11'b1000_0000_000, 2'b00, 2'b10, 2'b00, 6'b000000, 1'b0};
`endif

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; opcode = 6'd0; funct = 6'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++;
    if (ctrl !== C_IDLE) begin errors++; $display("FAIL reset_ctrl got %h want %h", ctrl, C_IDLE); end
    checks++;
    if (instr_retired !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_retired); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    logic [27:0] exp [6];
    opcode = 6'b000000; funct = 6'b100000;
    exp[0] = {4'd0, C_IDLE};  exp[1] = {4'd1, C_FETCH}; exp[2] = {4'd2, C_DEC};
    exp[3] = {4'd7, C_REXADD}; exp[4] = {4'd8, C_RWB}; exp[5] = {4'd1, C_FETCH};
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL add cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== 32'd1) begin errors++; $display("FAIL add_count got %0d want 1", instr_retired); end
  endtask

  task automatic test_lw_wait();
    logic [27:0] exp [10];
    logic        mr  [10];
    opcode = 6'b100011;
    exp[0] = {4'd1, C_FETCHW}; mr[0] = 1'b0;
    exp[1] = {4'd1, C_FETCH};  mr[1] = 1'b1;
    exp[2] = {4'd2, C_DEC};    mr[2] = 1'b1;
    exp[3] = {4'd3, C_MEMADR}; mr[3] = 1'b1;
    exp[4] = {4'd4, C_MEMRD};  mr[4] = 1'b0;
    exp[5] = {4'd4, C_MEMRD};  mr[5] = 1'b0;
    exp[6] = {4'd4, C_MEMRD};  mr[6] = 1'b0;
    exp[7] = {4'd4, C_MEMRD};  mr[7] = 1'b1;
    exp[8] = {4'd5, C_MEMWB};  mr[8] = 1'b1;
    exp[9] = {4'd1, C_FETCH};  mr[9] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL lw cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 9) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== 32'd2) begin errors++; $display("FAIL lw_count got %0d want 2", instr_retired); end
  endtask

  task automatic test_ori();
    logic [27:0] exp [5];
    opcode = 6'b001101;
    exp[0] = {4'd1, C_FETCH}; exp[1] = {4'd2, C_DEC}; exp[2] = {4'd10, C_IEXORI};
    exp[3] = {4'd11, C_IWB};  exp[4] = {4'd1, C_FETCH};
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL ori cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== 32'd3) begin errors++; $display("FAIL ori_count got %0d want 3", instr_retired); end
  endtask

  task automatic test_beq_illegal();
    logic [27:0] exp [6];
    opcode = 6'b000100;
    exp[0] = {4'd1, C_FETCH}; exp[1] = {4'd2, C_DEC};    exp[2] = {4'd9, C_BEQ};
    exp[3] = {4'd1, C_FETCH}; exp[4] = {4'd2, C_DECILL}; exp[5] = {4'd1, C_FETCH};
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      if (i == 3) opcode = 6'b111111;
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL beq_ill cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== 32'd4) begin errors++; $display("FAIL beq_ill_count got %0d want 4", instr_retired); end
  endtask

  task automatic test_reset_in_memwr();
    logic [27:0] exp [4];
    logic        mr  [4];
    opcode = 6'b101011;
    exp[0] = {4'd1, C_FETCH};  mr[0] = 1'b1;
    exp[1] = {4'd2, C_DEC};    mr[1] = 1'b1;
    exp[2] = {4'd3, C_MEMADR}; mr[2] = 1'b0;
    exp[3] = {4'd6, C_MEMWR};  mr[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ready = mr[i];
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL sw_abort cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({state, ctrl} !== {4'd0, C_IDLE}) begin
      errors++; $display("FAIL abort_outputs got %h want %h", {state, ctrl}, {4'd0, C_IDLE});
    end
    checks++;
    if (instr_retired !== 32'd0) begin errors++; $display("FAIL abort_count got %0d want 0", instr_retired); end
    @(posedge clk); #1;
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    checks++;
    if (state !== 4'd0) begin errors++; $display("FAIL abort_release got %0d want 0", state); end
    @(posedge clk); #1;
    checks++;
    if ({state, ctrl} !== {4'd1, C_FETCH}) begin
      errors++; $display("FAIL abort_refetch got %h want %h", {state, ctrl}, {4'd1, C_FETCH});
    end
  endtask

  task automatic test_sw();
    logic [27:0] exp [5];
    opcode = 6'b101011;
    exp[0] = {4'd1, C_FETCH}; exp[1] = {4'd2, C_DEC}; exp[2] = {4'd3, C_MEMADR};
    exp[3] = {4'd6, C_MEMWR}; exp[4] = {4'd1, C_FETCH};
    for (int i = 0; i < 5; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL sw cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== 32'd1) begin errors++; $display("FAIL sw_count got %0d want 1", instr_retired); end
  endtask

  task automatic test_jump();
`ifdef MC_CONTROL_JUMP_EN
    localparam int N = 4;
    localparam logic [31:0] CNT = 32'd2;
    logic [27:0] exp [N];
    exp[0] = {4'd1, C_FETCH}; exp[1] = {4'd2, C_DEC}; exp[2] = {4'd12, C_JUMP}; exp[3] = {4'd1, C_FETCH};
`else
    localparam int N = 3;
    localparam logic [31:0] CNT = 32'd1;
    logic [27:0] exp [N];
    exp[0] = {4'd1, C_FETCH}; exp[1] = {4'd2, C_DECILL}; exp[2] = {4'd1, C_FETCH};
`endif
    opcode = 6'b000010;
    for (int i = 0; i < N; i++) begin
      mem_ready = 1'b1;
      #1;
      checks++;
      if ({state, ctrl} !== exp[i]) begin
        errors++; $display("FAIL jump cyc%0d got %h want %h", i, {state, ctrl}, exp[i]);
      end
      if (i < N - 1) begin @(posedge clk); #1; end
    end
    checks++;
    if (instr_retired !== CNT) begin errors++; $display("FAIL jump_count got %0d want %0d", instr_retired, CNT); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_ori();
    test_beq_illegal();
    test_reset_in_memwr();
    test_sw();
    test_jump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle main control unit for the MIPS datapath: a Moore state machine that sequences fetch, decode, execute, memory and write-back for each instruction. It sits directly upstream of the ALU control unit: it drives the 2-bit ALUOp and the 6-bit function code that unit decodes into the 3-bit ALU control. It also drives every datapath mux and write-enable. Supported instructions are add, sub, and, or, slt, addi, andi, ori, lw, sw and beq, plus j as an optional feature.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction bits [31:26], taken from the instruction register (IR).
- funct  in  6  instruction bits [5:0], taken from the IR.
- mem_ready  in  1  memory completes the current read or write this cycle.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt  out  1 each  datapath controls.
- ALUSrcB  out  2  ALU operand B select: 00 reg, 01 const 4, 10 immediate, 11 immediate<<2.
- PCSource  out  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  2  ALUOp code sent to the ALU control unit.
- alu_funct  out  6  function code sent to the ALU control unit.
- illegal_op  out  1  one-cycle pulse when an opcode is unsupported.
- state  out  4  current state, for debug.
- instr_retired  out  32  count of completed instructions; wraps at 2^32.

## Operation
State encoding: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, REX=7, RWB=8, BEQ=9, IEX=10, IWB=11, JUMP=12. Encodings 13–15 go to IDLE on the next edge.

Outputs are decoded from state only; any output not listed below is 0.

- IDLE: entered on reset; every output is 0. Always goes to FETCH.
- FETCH: MemRead=1, ALUSrcB=01, ALUOp=00. PCWrite and IRWrite both equal mem_ready. Holds until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcB=11, ALUOp=00 (computes the branch target). Next state by opcode:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 (R-type): REX.
  - 000100 (beq): BEQ.
  - 001000 (addi), 001100 (andi), 001101 (ori): IEX.
  - 000010 (j): see Configuration.
  - any other opcode: illegal_op=1 for this cycle, then FETCH with no writes.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1. Goes to FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds until mem_ready=1, then goes to FETCH.
- REX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, alu_funct=funct. Goes to RWB.
- RWB: RegDst=1, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Goes to FETCH.
- IEX: ALUSrcA=1, ALUSrcB=10, ALUOp=10. alu_funct is 100000 for addi, 100100 for andi, 100101 for ori. ZeroExt=1 for andi and ori only. Goes to IWB.
- IWB: RegWrite=1, RegDst=0. Goes to FETCH.
- alu_funct is 000000 in every state except REX and IEX.
- instr_retired increments by exactly 1 on each transition into FETCH from MEMWB, MEMWR, RWB, BEQ, IWB or JUMP.
  - It does not increment on IDLE→FETCH or on an illegal-opcode return to FETCH.

## Timing
- Reset values: state=IDLE, instr_retired=0, every output 0.
- rst asserted mid-instruction aborts it immediately: no further writes, counter cleared.
- The first FETCH occurs one cycle after rst deasserts.
- Cycles per instruction with mem_ready tied high:
  - lw: 5; sw: 4; R-type: 4; immediate ops: 4; beq: 3; j: 3.
- Each cycle that mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant while waiting.
- opcode and funct are sampled only in DECODE, MEMADR, REX and IEX; the IR must hold them stable from DECODE until the next FETCH.

## Configuration
- MC_CONTROL_JUMP_EN defined: opcode 000010 in DECODE goes to JUMP.
  - JUMP outputs PCWrite=1, PCSource=10, then goes to FETCH; j counts as retired.
- MC_CONTROL_JUMP_EN undefined:
  - JUMP state is not built.
  - Opcode 000010 is illegal: illegal_op pulses and the FSM returns to FETCH.
  - PCSource never takes the value 10.

## Test plan
- Reset, then add (opcode 000000, funct 100000) with mem_ready=1: states 0,1,2,7,8,1. In REX, ALUOp=10 and alu_funct=100000. In RWB, RegDst=1 and RegWrite=1. instr_retired=1.
- lw with mem_ready held low for 3 cycles in MEMRD: MEMRD lasts 4 cycles with MemRead=1 and IorD=1 throughout. MEMWB follows with MemtoReg=1. Total 8 cycles.
- ori (001101): in IEX, alu_funct=100101, ZeroExt=1, ALUSrcB=10. In IWB, RegWrite=1 and RegDst=0.
- beq then opcode 111111: BEQ asserts PCWriteCond=1, PCSource=01, ALUOp=01. The illegal opcode pulses illegal_op for one cycle in DECODE, with no write-enables. instr_retired rises by 1 only.
- rst asserted during MEMWR: all outputs go to 0 immediately, instr_retired=0, and FETCH resumes one cycle after release.
- j (000010): with MC_CONTROL_JUMP_EN, JUMP asserts PCWrite=1 and PCSource=10. Without it, illegal_op pulses and the FSM returns to FETCH.
